sopp_flow_ctrl: RTL and testbench
=================================

Name: sopp_flow_ctrl

Overview:
Program-flow controller for the scalar unit. It executes SOPP-class instructions: NOP, SLEEP, WAITCNT, BARRIER, ENDPGM, BRANCH and the CBRANCH_SCC0/SCC1/VCCZ/VCCNZ/EXECZ/EXECNZ forms. It sits between the scalar decode stage and fetch. It stalls issue, gates on outstanding-memory counters, performs the barrier handshake and redirects the PC.

Parameters:
PC_W, 64, program counter width
SLEEP_UNIT, 64, clock cycles per S_SLEEP count
VM_W, 6, width of vm_cnt and the vmcnt threshold
EXP_W, 3, width of exp_cnt and the expcnt threshold
LGKM_W, 4, width of lgkm_cnt and the lgkmcnt threshold

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_valid  in  1  SOPP instruction present
inst_ready  out  1  controller can accept
inst_op  in  8  SOPP opcode
inst_simm16  in  16  SIMM16 field
inst_pc  in  PC_W  byte address of this instruction
scc  in  1  scalar condition code
vccz  in  1  VCC is zero
execz  in  1  EXEC is zero
vm_cnt  in  VM_W  outstanding vector-memory ops
exp_cnt  in  EXP_W  outstanding exports
lgkm_cnt  in  LGKM_W  outstanding LDS/GDS/constant/message ops
barrier_req  out  1  wave has arrived at the barrier
barrier_release  in  1  workgroup barrier satisfied
redirect_valid  out  1  one-cycle pulse: fetch must jump
redirect_pc  out  PC_W  jump target
endpgm  out  1  one-cycle pulse on ENDPGM
halted  out  1  wave has ended
wave_start  in  1  re-arm after halt
illegal_op  out  1  one-cycle pulse for an unsupported SOPP opcode

Behaviour:
- Reset values: inst_ready=0, state=HALTED, halted=1. All pulse outputs, barrier_req and redirect_pc are 0.
- States: IDLE, COUNT, WAIT, BARRIER, HALTED.
- inst_ready=1 only in IDLE. An instruction is accepted on inst_valid&inst_ready. Operands are captured at accept.
- HALTED -> IDLE on wave_start. In any other state wave_start is ignored.
- Branch target = inst_pc + 4 + (sign_extend(simm16) << 2), computed modulo 2^PC_W.
- BRANCH: the cycle after accept, redirect_valid=1 and redirect_pc=target. State stays IDLE.
- CBRANCH_*: the condition (SCC0: !scc, SCC1: scc, VCCZ: vccz, VCCNZ: !vccz, EXECZ: execz, EXECNZ: !execz) is sampled at the accept edge. If taken, redirect as for BRANCH. If not taken, no pulse. State stays IDLE.
- NOP: load counter = simm16[3:0]+1 and go to COUNT. Decrement each cycle; return to IDLE when the counter reaches 0. Total stall = simm16[3:0]+1 cycles with inst_ready low.
- SLEEP: counter = simm16[6:0]*SLEEP_UNIT. A value of 0 returns to IDLE the next cycle.
- WAITCNT thresholds:
  - vmcnt = {simm16[15:14], simm16[3:0]}
  - expcnt = simm16[6:4]
  - lgkmcnt = simm16[11:8]
- WAITCNT: go to WAIT. Return to IDLE in the cycle after vm_cnt<=vmcnt, exp_cnt<=expcnt and lgkm_cnt<=lgkmcnt all hold, evaluated every cycle using live counters.
- BARRIER: go to BARRIER with barrier_req=1 held until the cycle barrier_release is sampled high. Then barrier_req=0 and state returns to IDLE.
- A barrier_release that arrives while not in BARRIER is ignored.
- ENDPGM: endpgm pulses the cycle after accept, the wave moves to HALTED and halted=1.
- Any other opcode: illegal_op pulses the cycle after accept. The instruction is treated as a 1-cycle NOP.
- No back-to-back accept after a multi-cycle instruction: at least one cycle elapses between accepts of COUNT, WAIT or BARRIER instructions. Single-cycle ops (branches, illegal) may be accepted every cycle.
- Asynchronous reset mid-operation aborts any count, wait or barrier immediately. barrier_req drops and the block returns to reset values.

Test Plan:
- Reset then wave_start; accept NOP (op 0) with simm16=3 -> inst_ready low 4 cycles, then high; no redirect.
- BRANCH at inst_pc=0x100, simm16=0xFFFE -> redirect_valid 1 cycle, redirect_pc=0xFC.
- CBRANCH_SCC1 at pc 0x200, simm16=5: with scc=0 -> no redirect; with scc=1 -> redirect_pc=0x218.
- WAITCNT simm16=0x0F70 (expcnt=7, lgkmcnt=15, vmcnt=0) with vm_cnt=3 decrementing by 1 per cycle -> ready returns the cycle after vm_cnt=0.
- BARRIER: barrier_req rises after accept and stays high 10 cycles; pulse barrier_release -> barrier_req drops, IDLE. Separately, assert rst_n=0 during BARRIER -> barrier_req=0 immediately, halted=1.
- ENDPGM -> endpgm pulse, halted=1, inst_ready=0 until wave_start. Opcode 99 -> illegal_op pulse, 1-cycle stall.

Source files
------------

// File: rtl/sopp_flow_ctrl.sv
// sopp_flow_ctrl
//
// Program-flow controller for the scalar unit. It executes SOPP-class
// instructions between scalar decode and fetch: it stalls issue, gates on
// outstanding-memory counters, runs the barrier handshake, redirects the PC
// and ends the wave.
//
// Opcode map (8-bit SOPP op field):
//   0 NOP, 1 ENDPGM, 2 BRANCH, 4 CBRANCH_SCC0, 5 CBRANCH_SCC1,
//   6 CBRANCH_VCCZ, 7 CBRANCH_VCCNZ, 8 CBRANCH_EXECZ, 9 CBRANCH_EXECNZ,
//   10 BARRIER, 12 WAITCNT, 14 SLEEP. Every other value is illegal.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   inst_valid/ready  instruction handshake (ready only while idle)
//   inst_op           SOPP opcode
//   inst_simm16       SIMM16 immediate
//   inst_pc           byte address of the instruction
//   scc, vccz, execz  branch conditions, sampled at accept
//   vm_cnt, exp_cnt,
//   lgkm_cnt          live outstanding-operation counters for WAITCNT
//   barrier_req       high while the wave waits at a barrier
//   barrier_release   workgroup barrier satisfied
//   redirect_valid    one-cycle pulse: fetch must jump to redirect_pc
//   redirect_pc       jump target
//   endpgm            one-cycle pulse when ENDPGM retires
//   halted            wave has ended
//   wave_start        re-arms the controller after a halt
//   illegal_op        one-cycle pulse for an unsupported opcode
module sopp_flow_ctrl #(
  parameter int PC_W       = 64,
  parameter int SLEEP_UNIT = 64,
  parameter int VM_W       = 6,
  parameter int EXP_W      = 3,
  parameter int LGKM_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [7:0]        inst_op,
  input  logic [15:0]       inst_simm16,
  input  logic [PC_W-1:0]   inst_pc,
  input  logic              scc,
  input  logic              vccz,
  input  logic              execz,
  input  logic [VM_W-1:0]   vm_cnt,
  input  logic [EXP_W-1:0]  exp_cnt,
  input  logic [LGKM_W-1:0] lgkm_cnt,
  output logic              barrier_req,
  input  logic              barrier_release,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              endpgm,
  output logic              halted,
  input  logic              wave_start,
  output logic              illegal_op
);

  localparam logic [7:0] OP_NOP      = 8'd0;
  localparam logic [7:0] OP_ENDPGM   = 8'd1;
  localparam logic [7:0] OP_BRANCH   = 8'd2;
  localparam logic [7:0] OP_CB_SCC0  = 8'd4;
  localparam logic [7:0] OP_CB_SCC1  = 8'd5;
  localparam logic [7:0] OP_CB_VCCZ  = 8'd6;
  localparam logic [7:0] OP_CB_VCCNZ = 8'd7;
  localparam logic [7:0] OP_CB_EXECZ = 8'd8;
  localparam logic [7:0] OP_CB_EXECNZ= 8'd9;
  localparam logic [7:0] OP_BARRIER  = 8'd10;
  localparam logic [7:0] OP_WAITCNT  = 8'd12;
  localparam logic [7:0] OP_SLEEP    = 8'd14;

  // Counter must hold the longest sleep (127 * SLEEP_UNIT) and a NOP of 16.
  localparam int CNT_RAW = $clog2(128 * SLEEP_UNIT + 1);
  localparam int CNT_W   = (CNT_RAW < 5) ? 5 : CNT_RAW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_WAIT,
    ST_BARRIER,
    ST_HALTED
  } state_t;

  state_t state_q, state_d;

  // Target = pc + 4 + sign_extend(simm16) * 4, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] branch_target(
    input logic [PC_W-1:0] pc,
    input logic [15:0]     simm
  );
    logic signed [PC_W-1:0] offs;
    offs = {{(PC_W-16){simm[15]}}, simm};
    offs = offs <<< 2;
    return pc + PC_W'(4) + offs;
  endfunction

  function automatic logic cbranch_taken(
    input logic [7:0] op,
    input logic       c_scc,
    input logic       c_vccz,
    input logic       c_execz
  );
    logic taken;
    case (op)
      OP_CB_SCC0:   taken = ~c_scc;
      OP_CB_SCC1:   taken = c_scc;
      OP_CB_VCCZ:   taken = c_vccz;
      OP_CB_VCCNZ:  taken = ~c_vccz;
      OP_CB_EXECZ:  taken = c_execz;
      OP_CB_EXECNZ: taken = ~c_execz;
      default:      taken = 1'b0;
    endcase
    return taken;
  endfunction

  function automatic logic waitcnt_met(
    input logic [VM_W-1:0]   vm,
    input logic [EXP_W-1:0]  ex,
    input logic [LGKM_W-1:0] lg,
    input logic [VM_W-1:0]   vm_thr,
    input logic [EXP_W-1:0]  ex_thr,
    input logic [LGKM_W-1:0] lg_thr
  );
    return (vm <= vm_thr) && (ex <= ex_thr) && (lg <= lg_thr);
  endfunction

  logic              accept_p0;
  logic              redirect_vld_p0;
  logic              endpgm_vld_p0;
  logic              illegal_vld_p0;
  logic              cnt_load_p0;
  logic [CNT_W-1:0]  cnt_val_p0;
  logic              thr_load_p0;

  logic              redirect_vld_p1;
  logic [PC_W-1:0]   redirect_pc_p1;
  logic              endpgm_vld_p1;
  logic              illegal_vld_p1;

  logic [CNT_W-1:0]  cnt_q;
  logic [VM_W-1:0]   vm_thr_q;
  logic [EXP_W-1:0]  exp_thr_q;
  logic [LGKM_W-1:0] lgkm_thr_q;

  assign inst_ready = (state_q == ST_IDLE);
  assign accept_p0  = inst_valid & inst_ready;

  // ---- p0: decode of the accepted instruction and next-state logic ----
  always_comb begin
    state_d         = state_q;
    redirect_vld_p0 = 1'b0;
    endpgm_vld_p0   = 1'b0;
    illegal_vld_p0  = 1'b0;
    cnt_load_p0     = 1'b0;
    cnt_val_p0      = '0;
    thr_load_p0     = 1'b0;
    case (state_q)
      ST_HALTED: begin
        if (wave_start) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept_p0) begin
          case (inst_op)
            OP_NOP: begin
              state_d     = ST_COUNT;
              cnt_load_p0 = 1'b1;
              cnt_val_p0  = CNT_W'(inst_simm16[3:0]) + CNT_W'(1);
            end
            OP_SLEEP: begin
              // A zero count still spends one cycle in COUNT.
              state_d     = ST_COUNT;
              cnt_load_p0 = 1'b1;
              cnt_val_p0  = CNT_W'(inst_simm16[6:0]) * CNT_W'(SLEEP_UNIT);
            end
            OP_WAITCNT: begin
              state_d     = ST_WAIT;
              thr_load_p0 = 1'b1;
            end
            OP_BARRIER: begin
              state_d = ST_BARRIER;
            end
            OP_ENDPGM: begin
              state_d       = ST_HALTED;
              endpgm_vld_p0 = 1'b1;
            end
            OP_BRANCH: begin
              redirect_vld_p0 = 1'b1;
            end
            OP_CB_SCC0, OP_CB_SCC1, OP_CB_VCCZ,
            OP_CB_VCCNZ, OP_CB_EXECZ, OP_CB_EXECNZ: begin
              redirect_vld_p0 = cbranch_taken(inst_op, scc, vccz, execz);
            end
            default: begin
              // Unsupported opcode behaves as a one-cycle NOP.
              illegal_vld_p0 = 1'b1;
              state_d        = ST_COUNT;
              cnt_load_p0    = 1'b1;
              cnt_val_p0     = CNT_W'(1);
            end
          endcase
        end
      end
      ST_COUNT: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (waitcnt_met(vm_cnt, exp_cnt, lgkm_cnt,
                        vm_thr_q, exp_thr_q, lgkm_thr_q))
          state_d = ST_IDLE;
      end
      ST_BARRIER: begin
        if (barrier_release) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // ---- p1: registered control state and output pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_HALTED;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= '0;
      endpgm_vld_p1   <= 1'b0;
      illegal_vld_p1  <= 1'b0;
    end else begin
      state_q         <= state_d;
      redirect_vld_p1 <= redirect_vld_p0;
      endpgm_vld_p1   <= endpgm_vld_p0;
      illegal_vld_p1  <= illegal_vld_p0;
      if (redirect_vld_p0)
        redirect_pc_p1 <= branch_target(inst_pc, inst_simm16);
    end
  end

  // Stall counter and WAITCNT thresholds are only read in the state that
  // loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cnt_load_p0)
      cnt_q <= cnt_val_p0;
    else if (state_q == ST_COUNT)
      cnt_q <= cnt_q - CNT_W'(1);
    if (thr_load_p0) begin
      vm_thr_q   <= VM_W'({inst_simm16[15:14], inst_simm16[3:0]});
      exp_thr_q  <= EXP_W'(inst_simm16[6:4]);
      lgkm_thr_q <= LGKM_W'(inst_simm16[11:8]);
    end
  end

  assign barrier_req    = (state_q == ST_BARRIER);
  assign halted         = (state_q == ST_HALTED);
  assign redirect_valid = redirect_vld_p1;
  assign redirect_pc    = redirect_pc_p1;
  assign endpgm         = endpgm_vld_p1;
  assign illegal_op     = illegal_vld_p1;

endmodule

// File: tb/tb_sopp_flow_ctrl.sv
module tb_sopp_flow_ctrl;

  localparam int PC_W = 64;

  localparam logic [7:0] OP_NOP     = 8'd0;
  localparam logic [7:0] OP_ENDPGM  = 8'd1;
  localparam logic [7:0] OP_BRANCH  = 8'd2;
  localparam logic [7:0] OP_BARRIER = 8'd10;
  localparam logic [7:0] OP_WAITCNT = 8'd12;
  localparam logic [7:0] OP_SLEEP   = 8'd14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            inst_valid = 1'b0;
  logic            inst_ready;
  logic [7:0]      inst_op = 8'd0;
  logic [15:0]     inst_simm16 = 16'd0;
  logic [PC_W-1:0] inst_pc = '0;
  logic            scc = 1'b0;
  logic            vccz = 1'b0;
  logic            execz = 1'b0;
  logic [5:0]      vm_cnt = 6'd0;
  logic [2:0]      exp_cnt = 3'd0;
  logic [3:0]      lgkm_cnt = 4'd0;
  logic            barrier_req;
  logic            barrier_release = 1'b0;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            endpgm;
  logic            halted;
  logic            wave_start = 1'b0;
  logic            illegal_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sopp_flow_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_op         (inst_op),
    .inst_simm16     (inst_simm16),
    .inst_pc         (inst_pc),
    .scc             (scc),
    .vccz            (vccz),
    .execz           (execz),
    .vm_cnt          (vm_cnt),
    .exp_cnt         (exp_cnt),
    .lgkm_cnt        (lgkm_cnt),
    .barrier_req     (barrier_req),
    .barrier_release (barrier_release),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .endpgm          (endpgm),
    .halted          (halted),
    .wave_start      (wave_start),
    .illegal_op      (illegal_op)
  );

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] model_target(input logic [63:0] pc, input logic [15:0] simm);
    longint off;
    off = $signed(simm);
    off = off * 4;
    return pc + 64'd4 + 64'(off);
  endfunction

  function automatic logic model_taken(input logic [7:0] op, input logic s, input logic v, input logic e);
    case (op)
      8'd4: return !s;
      8'd5: return s;
      8'd6: return v;
      8'd7: return !v;
      8'd8: return e;
      8'd9: return !e;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_wait_met(input logic [15:0] simm, input int vm, input int ex, input int lg);
    int vthr, ethr, lthr;
    vthr = int'(simm[15:14]) * 16 + int'(simm[3:0]);
    ethr = int'(simm[6:4]);
    lthr = int'(simm[11:8]);
    return (vm <= vthr) && (ex <= ethr) && (lg <= lthr);
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] simm, input logic [63:0] pc);
    inst_valid  = 1'b1;
    inst_op     = op;
    inst_simm16 = simm;
    inst_pc     = pc;
    step();
    inst_valid  = 1'b0;
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (inst_ready !== 1'b1 && n < 20000) begin
      n++;
      step();
    end
  endtask

  task automatic start_wave();
    wave_start = 1'b1;
    step();
    wave_start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    step();
    step();
    total++; if (inst_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", inst_ready); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted got=%b want=1", halted); end
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b want=0", redirect_valid); end
    total++; if (redirect_pc !== 64'd0) begin bad++; $display("FAIL reset_redirect_pc got=%h want=0", redirect_pc); end
    total++; if (endpgm !== 1'b0 || illegal_op !== 1'b0 || barrier_req !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got=%b%b%b want=000", endpgm, illegal_op, barrier_req);
    end
    rst_n = 1'b1;
    repeat (3) step();
    total++; if (halted !== 1'b1 || inst_ready !== 1'b0) begin
      bad++; $display("FAIL halted_until_start got halted=%b ready=%b want 1/0", halted, inst_ready);
    end
    start_wave();
    total++; if (inst_ready !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL wave_start got ready=%b halted=%b want 1/0", inst_ready, halted);
    end
  endtask

  task automatic test_nop();
    int n;
    logic [15:0] s;
    for (int i = 0; i < 6; i++) begin
      s = (i == 0) ? 16'd3 : 16'($urandom);
      issue(OP_NOP, s, 64'h40);
      total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL nop_redirect got=%b want=0", redirect_valid); end
      count_low(n);
      total++; if (n != int'(s[3:0]) + 1) begin
        bad++; $display("FAIL nop_stall simm=%h got=%0d want=%0d", s, n, int'(s[3:0]) + 1);
      end
    end
  endtask

  task automatic test_sleep();
    int n, k, want;
    logic [15:0] s;
    for (int i = 0; i < 3; i++) begin
      k = i;
      s = (16'($urandom) & 16'hFF80) | 16'(k);
      issue(OP_SLEEP, s, 64'h80);
      count_low(n);
      want = (k == 0) ? 1 : k * 64;
      total++; if (n != want) begin bad++; $display("FAIL sleep_stall k=%0d got=%0d want=%0d", k, n, want); end
    end
  endtask

  task automatic test_branch();
    logic [63:0] pc, want;
    logic [15:0] s;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin pc = 64'h100; s = 16'hFFFE; end
      else begin pc = {32'($urandom), 32'($urandom)} & ~64'd3; s = 16'($urandom); end
      want = model_target(pc, s);
      issue(OP_BRANCH, s, pc);
      total++; if (redirect_valid !== 1'b1) begin bad++; $display("FAIL branch_valid got=%b want=1", redirect_valid); end
      total++; if (redirect_pc !== want) begin bad++; $display("FAIL branch_pc got=%h want=%h", redirect_pc, want); end
      total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL branch_idle got=%b want=1", inst_ready); end
      step();
      total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL branch_pulse got=%b want=0", redirect_valid); end
    end
  endtask

  task automatic test_cbranch();
    logic [7:0] op;
    logic [63:0] pc, want;
    logic [15:0] s;
    logic tk;
    scc = 1'b0;
    issue(8'd5, 16'd5, 64'h200);
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL cb_scc1_nt got=%b want=0", redirect_valid); end
    scc = 1'b1;
    issue(8'd5, 16'd5, 64'h200);
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h218) begin
      bad++; $display("FAIL cb_scc1_t got=%b/%h want=1/218", redirect_valid, redirect_pc);
    end
    for (int i = 0; i < 16; i++) begin
      op    = 8'(4 + ($urandom % 6));
      scc   = 1'($urandom);
      vccz  = 1'($urandom);
      execz = 1'($urandom);
      pc    = 64'($urandom) & ~64'd3;
      s     = 16'($urandom);
      tk    = model_taken(op, scc, vccz, execz);
      want  = model_target(pc, s);
      issue(op, s, pc);
      // Conditions changing after accept must not matter.
      scc = ~scc; vccz = ~vccz; execz = ~execz;
      total++; if (redirect_valid !== tk) begin
        bad++; $display("FAIL cb_taken op=%0d got=%b want=%b", op, redirect_valid, tk);
      end
      if (tk) begin
        total++; if (redirect_pc !== want) begin bad++; $display("FAIL cb_pc op=%0d got=%h want=%h", op, redirect_pc, want); end
      end
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [63:0] pc, want;
    logic [15:0] s;
    inst_valid = 1'b1;
    inst_op    = OP_BRANCH;
    for (int i = 0; i < 5; i++) begin
      pc = 64'h1000 + 64'(i * 64);
      s  = 16'($urandom);
      inst_pc = pc;
      inst_simm16 = s;
      want = model_target(pc, s);
      step();
      total++; if (redirect_valid !== 1'b1 || redirect_pc !== want) begin
        bad++; $display("FAIL b2b_branch i=%0d got=%b/%h want=1/%h", i, redirect_valid, redirect_pc, want);
      end
    end
    inst_valid = 1'b0;
    step();
  endtask

  task automatic test_waitcnt();
    logic [15:0] s;
    int vm, ex, lg;
    logic met;
    logic done;
    for (int t = 0; t < 5; t++) begin
      if (t == 0) begin s = 16'h0F70; vm = 3; ex = 0; lg = 0; end
      else begin s = 16'($urandom); vm = $urandom_range(0, 63); ex = $urandom_range(0, 7); lg = $urandom_range(0, 15); end
      vm_cnt = 6'(vm); exp_cnt = 3'(ex); lgkm_cnt = 4'(lg);
      issue(OP_WAITCNT, s, 64'h300);
      total++; if (inst_ready !== 1'b0) begin bad++; $display("FAIL wait_enter got=%b want=0", inst_ready); end
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
        if (t == 0) vm = (vm > 0) ? vm - 1 : 0;
        else begin
          vm = (vm > 3) ? vm - $urandom_range(0, 3) : 0;
          ex = (ex > 0) ? ex - $urandom_range(0, 1) : 0;
          lg = (lg > 1) ? lg - $urandom_range(0, 2) : 0;
        end
        vm_cnt = 6'(vm); exp_cnt = 3'(ex); lgkm_cnt = 4'(lg);
        met = model_wait_met(s, vm, ex, lg);
        step();
        total++; if (inst_ready !== met) begin
          bad++; $display("FAIL wait_ready t=%0d cyc=%0d got=%b want=%b", t, c, inst_ready, met);
        end
        done = met || (inst_ready === 1'b1);
      end
      total++; if (!done) begin bad++; $display("FAIL wait_timeout t=%0d got=busy want=idle", t); end
    end
    vm_cnt = 6'd0; exp_cnt = 3'd0; lgkm_cnt = 4'd0;
  endtask

  task automatic test_barrier();
    int hold;
    barrier_release = 1'b1;
    step();
    barrier_release = 1'b0;
    total++; if (inst_ready !== 1'b1 || barrier_req !== 1'b0) begin
      bad++; $display("FAIL stray_release got ready=%b req=%b want 1/0", inst_ready, barrier_req);
    end
    for (int t = 0; t < 2; t++) begin
      hold = (t == 0) ? 10 : $urandom_range(1, 6);
      issue(OP_BARRIER, 16'd0, 64'h400);
      for (int c = 0; c < hold; c++) begin
        total++; if (barrier_req !== 1'b1 || inst_ready !== 1'b0) begin
          bad++; $display("FAIL barrier_hold cyc=%0d got req=%b ready=%b want 1/0", c, barrier_req, inst_ready);
        end
        step();
      end
      barrier_release = 1'b1;
      step();
      barrier_release = 1'b0;
      total++; if (barrier_req !== 1'b0 || inst_ready !== 1'b1) begin
        bad++; $display("FAIL barrier_release got req=%b ready=%b want 0/1", barrier_req, inst_ready);
      end
    end
    issue(OP_BARRIER, 16'd0, 64'h400);
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++; if (barrier_req !== 1'b0 || halted !== 1'b1 || inst_ready !== 1'b0) begin
      bad++; $display("FAIL barrier_reset got req=%b halted=%b ready=%b want 0/1/0", barrier_req, halted, inst_ready);
    end
    #2 rst_n = 1'b1;
    step();
    start_wave();
  endtask

  task automatic test_endpgm();
    wave_start = 1'b1;
    step();
    wave_start = 1'b0;
    total++; if (inst_ready !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL idle_wave_start got ready=%b halted=%b want 1/0", inst_ready, halted);
    end
    issue(OP_ENDPGM, 16'd0, 64'h500);
    total++; if (endpgm !== 1'b1 || halted !== 1'b1 || inst_ready !== 1'b0) begin
      bad++; $display("FAIL endpgm got pulse=%b halted=%b ready=%b want 1/1/0", endpgm, halted, inst_ready);
    end
    step();
    total++; if (endpgm !== 1'b0) begin bad++; $display("FAIL endpgm_pulse got=%b want=0", endpgm); end
    inst_valid = 1'b1; inst_op = OP_BRANCH;
    repeat (3) step();
    inst_valid = 1'b0;
    total++; if (inst_ready !== 1'b0 || redirect_valid !== 1'b0 || halted !== 1'b1) begin
      bad++; $display("FAIL halted_ignore got ready=%b redir=%b halted=%b want 0/0/1", inst_ready, redirect_valid, halted);
    end
    start_wave();
    total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL restart got=%b want=1", inst_ready); end
  endtask

  task automatic test_illegal();
    logic [7:0] ops [4];
    ops[0] = 8'd99; ops[1] = 8'd3; ops[2] = 8'd11; ops[3] = 8'd255;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 16'($urandom), 64'h600);
      total++; if (illegal_op !== 1'b1 || inst_ready !== 1'b0) begin
        bad++; $display("FAIL illegal op=%0d got pulse=%b ready=%b want 1/0", ops[i], illegal_op, inst_ready);
      end
      step();
      total++; if (illegal_op !== 1'b0 || inst_ready !== 1'b1 || redirect_valid !== 1'b0) begin
        bad++; $display("FAIL illegal_after op=%0d got pulse=%b ready=%b redir=%b want 0/1/0", ops[i], illegal_op, inst_ready, redirect_valid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nop();
    test_sleep();
    test_branch();
    test_cbranch();
    test_back_to_back();
    test_waitcnt();
    test_barrier();
    test_endpgm();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
